// File: rtl/video_rx_monitor_if.sv
// Parallel RGB565 LCD video bus: sync strobes, active-pixel qualifier
// and the 5/6/5 colour channels.
interface video_rx_monitor_if;
   logic       hsync;
   logic       vsync;
   logic       disp_en;
   logic [4:0] r;
   logic [5:0] g;
   logic [4:0] b;

   modport master (output hsync, vsync, disp_en, r, g, b);
   modport slave  (input  hsync, vsync, disp_en, r, g, b);
endinterface

// File: rtl/video_rx_monitor.sv
// Receive-side checker for an RGB565 LCD video stream. Measures line and
// frame timing, active-area size and a CRC-16/CCITT-FALSE of the active
// pixels of every frame, and declares lock once consecutive frames agree.
module video_rx_monitor #(
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CW        = 12
) (
   input  logic                 pclk,
   input  logic                 reset,
   video_rx_monitor_if.slave    vid,
   output logic [CW-1:0]        h_total,
   output logic [CW-1:0]        h_active,
   output logic [CW-1:0]        v_total,
   output logic [CW-1:0]        v_active,
   output logic [15:0]          frame_crc,
   output logic                 crc_stable,
   output logic                 frame_done,
   output logic [15:0]          frame_count,
   output logic                 locked,
   output logic [7:0]           mismatch_count,
   output logic                 overflow
);

   typedef enum logic [1:0] {IDLE, ACQ, CHECK, LOCKED} state_t;

   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [15:0]   CRC_INIT = 16'hFFFF;

   // One 16-bit pixel shifted MSB first through polynomial 0x1021.
   function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [15:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // Input stage and previous-sample registers.
   logic        hs_q, hs_p, vs_q, vs_p, de_q;
   logic [15:0] pix_q;
   logic        hs_edge, vs_edge;

   // Timing / content accumulators for the frame in progress.
   logic [CW-1:0] line_cnt, de_cnt;
   logic [CW-1:0] h_total_acc, h_active_acc, v_total_acc, v_active_acc;
   logic          ovf_acc;
   logic [15:0]   crc_acc;

   // Next values, with the current cycle's line close already folded in.
   logic [CW-1:0] line_nx, de_nx;
   logic [CW-1:0] ht_c, ha_c, vt_c, va_c;
   logic          sat_c, ovf_c, frame_match;
   logic [15:0]   crc_c;

   state_t state;

   assign hs_edge = (hs_p != HSYNC_POL) && (hs_q == HSYNC_POL);
   assign vs_edge = (vs_p != VSYNC_POL) && (vs_q == VSYNC_POL);

   // Register the pins once; sync history resets to the deasserted level so
   // leaving reset never fakes an assert edge.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         // NOTE: every clocked register uses <= so all of them see the same pre-edge values.
         hs_q  <= ~HSYNC_POL;
         hs_p  <= ~HSYNC_POL;
         vs_q  <= ~VSYNC_POL;
         vs_p  <= ~VSYNC_POL;
         de_q  <= 1'b0;
         pix_q <= '0;
      end else begin
         hs_q  <= vid.hsync;
         hs_p  <= hs_q;
         vs_q  <= vid.vsync;
         vs_p  <= vs_q;
         de_q  <= vid.disp_en;
         pix_q <= {vid.r, vid.g, vid.b};
      end
   end

   // Line bookkeeping: close the current line on an hsync edge and flag any
   // counter that tries to step past its maximum.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch can be inferred.
      line_nx = line_cnt;
      de_nx   = de_cnt;
      ht_c    = h_total_acc;
      ha_c    = h_active_acc;
      vt_c    = v_total_acc;
      va_c    = v_active_acc;
      sat_c   = 1'b0;
      crc_c   = crc_acc;

      if (hs_edge)                 line_nx = CNT_ONE;
      else if (line_cnt == CNT_MAX) sat_c  = 1'b1;
      else                         line_nx = line_cnt + 1'b1;

      // A pixel on a sync edge cycle already belongs to the new line/frame.
      if (hs_edge || vs_edge)      de_nx = {{(CW-1){1'b0}}, de_q};
      else if (de_q) begin
         if (de_cnt == CNT_MAX)    sat_c = 1'b1;
         else                      de_nx = de_cnt + 1'b1;
      end

      if (hs_edge) begin
         ht_c = line_cnt;
         if (de_cnt != '0) ha_c = de_cnt;
         if (v_total_acc == CNT_MAX) sat_c = 1'b1;
         else                        vt_c  = v_total_acc + 1'b1;
         if (de_cnt != '0) begin
            if (v_active_acc == CNT_MAX) sat_c = 1'b1;
            else                         va_c  = v_active_acc + 1'b1;
         end
      end

      ovf_c = ovf_acc | sat_c;

      if (de_q && !vs_edge) crc_c = crc16_upd(crc_acc, pix_q);

      frame_match = (ht_c == h_total) && (ha_c == h_active) &&
                    (vt_c == v_total) && (va_c == v_active) && !ovf_c;
   end

   // Accumulators restart on every vsync edge, seeded with that cycle's pixel.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         line_cnt     <= '0;
         de_cnt       <= '0;
         h_total_acc  <= '0;
         h_active_acc <= '0;
         v_total_acc  <= '0;
         v_active_acc <= '0;
         ovf_acc      <= 1'b0;
         crc_acc      <= CRC_INIT;
      end else begin
         line_cnt <= line_nx;
         de_cnt   <= de_nx;
         if (vs_edge) begin
            h_total_acc  <= '0;
            h_active_acc <= '0;
            v_total_acc  <= '0;
            v_active_acc <= '0;
            ovf_acc      <= 1'b0;
            crc_acc      <= de_q ? crc16_upd(CRC_INIT, pix_q) : CRC_INIT;
         end else begin
            h_total_acc  <= ht_c;
            h_active_acc <= ha_c;
            v_total_acc  <= vt_c;
            v_active_acc <= va_c;
            ovf_acc      <= ovf_c;
            crc_acc      <= crc_c;
         end
      end
   end

   // Lock FSM with registered measurement outputs; every vsync edge outside
   // IDLE publishes the finished frame and pulses frame_done.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         h_total        <= '0;
         h_active       <= '0;
         v_total        <= '0;
         v_active       <= '0;
         frame_crc      <= '0;
         crc_stable     <= 1'b0;
         frame_done     <= 1'b0;
         frame_count    <= '0;
         locked         <= 1'b0;
         mismatch_count <= '0;
         overflow       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (vs_edge) begin
            if (state != IDLE) begin
               h_total     <= ht_c;
               h_active    <= ha_c;
               v_total     <= vt_c;
               v_active    <= va_c;
               overflow    <= ovf_c;
               frame_crc   <= crc_c;
               crc_stable  <= (crc_c == frame_crc);
               frame_count <= frame_count + 16'd1;
               frame_done  <= 1'b1;
            end
            case (state)
               IDLE:  state <= ACQ;
               ACQ:   state <= CHECK;
               CHECK: begin
                  if (frame_match) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (!frame_match) begin
                     state  <= CHECK;
                     locked <= 1'b0;
                     if (mismatch_count != 8'hFF) mismatch_count <= mismatch_count + 8'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_video_rx_monitor.sv
// Directed bench for video_rx_monitor. Frame geometry keeps the 525/480
// line but uses 6 lines (4 active) per frame to stay within a short run.
// Every frame starts with hsync and vsync asserting on the same cycle, so a
// v_total of V_TOT shows the shared line closed into the ending frame.
module tb_video_rx_monitor;

   localparam int H_TOT    = 525;
   localparam int H_ACT    = 480;
   localparam int HBP      = 40;
   localparam int HS_W     = 10;
   localparam int V_TOT    = 6;
   localparam int V_ACT    = 4;
   localparam int LONG_LEN = 5010;
   localparam int FLIP_L   = 2;
   localparam int FLIP_X   = HBP + 100;
   localparam int N_FD     = 12;

   typedef struct {
      int ht, ha, vt, va, crc, stab, fc, lk, mc, ovf, lat;
   } snap_t;

   logic        pclk;
   logic        reset;
   logic [11:0] h_total, h_active, v_total, v_active;
   logic [15:0] frame_crc, frame_count;
   logic        crc_stable, frame_done, locked, overflow;
   logic [7:0]  mismatch_count;

   int    n_chk = 0;
   int    n_err = 0;
   int    cyc   = 0;
   int    vs_cyc = 0;
   snap_t snaps[$];

   video_rx_monitor_if vid ();

   video_rx_monitor dut (
      .pclk           (pclk),
      .reset          (reset),
      .vid            (vid),
      .h_total        (h_total),
      .h_active       (h_active),
      .v_total        (v_total),
      .v_active       (v_active),
      .frame_crc      (frame_crc),
      .crc_stable     (crc_stable),
      .frame_done     (frame_done),
      .frame_count    (frame_count),
      .locked         (locked),
      .mismatch_count (mismatch_count),
      .overflow       (overflow)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   // Record every published frame as the DUT presents it.
   always @(negedge pclk) begin
      snap_t s;
      if (frame_done === 1'b1) begin
         s.ht   = int'(h_total);
         s.ha   = int'(h_active);
         s.vt   = int'(v_total);
         s.va   = int'(v_active);
         s.crc  = int'(frame_crc);
         s.stab = int'(crc_stable);
         s.fc   = int'(frame_count);
         s.lk   = int'(locked);
         s.mc   = int'(mismatch_count);
         s.ovf  = int'(overflow);
         s.lat  = cyc - vs_cyc;
         snaps.push_back(s);
      end
   end

   function automatic logic [15:0] pix_val(input int l, input int x, input bit flip);
      logic [15:0] p;
      p = 16'((l * 2053) ^ (x * 97) ^ 16'hA5C3);
      if (flip && l == FLIP_L && x == FLIP_X) p = p ^ 16'h0001;
      return p;
   endfunction

   function automatic int is_active(input int l, input int x);
      return (l >= 1 && l <= V_ACT && x >= HBP && x < HBP + H_ACT) ? 1 : 0;
   endfunction

   // Reference CRC-16/CCITT-FALSE: XOR the word into the register, then 16 shifts.
   function automatic int crc_frame(input bit flip);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int l = 0; l < V_TOT; l++)
         for (int x = 0; x < H_TOT; x++)
            if (is_active(l, x) != 0) begin
               c = c ^ pix_val(l, x, flip);
               for (int k = 0; k < 16; k++)
                  c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
      return int'(c);
   endfunction

   function automatic int all_outs_zero();
      return int'(|{h_total, h_active, v_total, v_active, frame_crc, crc_stable,
                    frame_done, frame_count, locked, mismatch_count, overflow});
   endfunction

   // One frame; line 0 opens with hsync and vsync asserting together.
   task automatic gen_frame(input int nlines, input int htot, input int long_line,
                            input bit flip, input int rst_line);
      int          len;
      logic [15:0] p;
      for (int l = 0; l < nlines; l++) begin
         len = (l == long_line) ? LONG_LEN : htot;
         for (int x = 0; x < len; x++) begin
            @(negedge pclk);
            if (l == rst_line && x == 100) begin
               check("locked_before_reset", int'(locked), 1);
               reset = 1'b0;
            end else if (l == rst_line && x == 101) begin
               check("reset_outputs_zero", all_outs_zero(), 0);
               check("reset_mismatch_count", int'(mismatch_count), 0);
               check("reset_frame_count", int'(frame_count), 0);
               reset = 1'b1;
            end
            if (l == 0 && x == 0) vs_cyc = cyc;
            vid.hsync   = (x < HS_W) ? 1'b0 : 1'b1;
            vid.vsync   = (l == 0) ? 1'b0 : 1'b1;
            vid.disp_en = (is_active(l, x) != 0);
            p = (is_active(l, x) != 0) ? pix_val(l, x, flip) : 16'h0000;
            vid.r = p[15:11];
            vid.g = p[10:5];
            vid.b = p[4:0];
         end
      end
   endtask

   // Expected values per published frame (index = frame_done number).
   int exp_ht[N_FD]   = '{525, 525, 525, 526, 525, 525, 525, 525, 4095, 525, 525, 525};
   int exp_lk[N_FD]   = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0};
   int exp_mc[N_FD]   = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 0};
   int exp_ovf[N_FD]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
   int exp_fc[N_FD]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 1};
   int exp_stab[N_FD] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
   int exp_flip[N_FD] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

   initial begin
      int crc_clean, crc_flip;
      crc_clean = crc_frame(1'b0);
      crc_flip  = crc_frame(1'b1);

      reset       = 1'b0;
      vid.hsync   = 1'b1;
      vid.vsync   = 1'b1;
      vid.disp_en = 1'b0;
      vid.r = '0;
      vid.g = '0;
      vid.b = '0;
      repeat (3) @(negedge pclk);
      check("reset_state_zero", all_outs_zero(), 0);
      reset = 1'b1;
      repeat (5) @(negedge pclk);

      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F0: IDLE -> ACQ at its start
      check("no_fd_in_idle", snaps.size(), 0);
      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F1
      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F2
      gen_frame(V_TOT, 526,   -1, 1'b0, -1);   // F3: 526-cycle lines
      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F4
      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F5
      gen_frame(V_TOT, H_TOT, -1, 1'b1, -1);   // F6: one pixel flipped
      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F7
      gen_frame(V_TOT, H_TOT, V_TOT - 1, 1'b0, -1);  // F8: last line hsync held off
      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F9
      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F10
      gen_frame(V_TOT, H_TOT, -1, 1'b0, 2);    // F11: reset pulse on line 2
      gen_frame(V_TOT, H_TOT, -1, 1'b0, -1);   // F12: opened by 1st edge after reset
      check("no_fd_after_first_edge", snaps.size(), 11);
      gen_frame(1, H_TOT, -1, 1'b0, -1);       // 2nd edge after reset closes F12

      check("fd_total", snaps.size(), N_FD);
      for (int i = 0; i < N_FD; i++) begin
         if (snaps.size() > i) begin
            check($sformatf("fd%0d_h_total", i),     snaps[i].ht,   exp_ht[i]);
            check($sformatf("fd%0d_h_active", i),    snaps[i].ha,   H_ACT);
            check($sformatf("fd%0d_v_total", i),     snaps[i].vt,   V_TOT);
            check($sformatf("fd%0d_v_active", i),    snaps[i].va,   V_ACT);
            check($sformatf("fd%0d_locked", i),      snaps[i].lk,   exp_lk[i]);
            check($sformatf("fd%0d_mismatch", i),    snaps[i].mc,   exp_mc[i]);
            check($sformatf("fd%0d_overflow", i),    snaps[i].ovf,  exp_ovf[i]);
            check($sformatf("fd%0d_frame_count", i), snaps[i].fc,   exp_fc[i]);
            check($sformatf("fd%0d_crc_stable", i),  snaps[i].stab, exp_stab[i]);
            check($sformatf("fd%0d_frame_crc", i),   snaps[i].crc,
                  (exp_flip[i] != 0) ? crc_flip : crc_clean);
            check($sformatf("fd%0d_latency", i),     snaps[i].lat,  2);
         end else begin
            check($sformatf("fd%0d_present", i), 0, 1);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
